// File: rtl/bytes_to_packets_if.sv
// bytes_to_packets_if: byte-in / symbol-out streaming bundle for bytes_to_packets.
// The slave modport is the packer's view of the bus; master is the surrounding logic.
interface bytes_to_packets_if #(
   parameter int BITS_PER_BYTE    = 8,
   parameter int BYTES_PER_SYMBOL = 8
);
   logic [BITS_PER_BYTE-1:0]                  asi_in0_data;
   logic                                      asi_in0_valid;
   logic                                      asi_in0_ready;
   logic [BYTES_PER_SYMBOL*BITS_PER_BYTE-1:0] aso_out0_data;
   logic                                      aso_out0_valid;
   logic                                      aso_out0_ready;
   logic                                      aso_out0_startofpacket;
   logic                                      aso_out0_endofpacket;

   modport slave (
      input  asi_in0_data,
      input  asi_in0_valid,
      output asi_in0_ready,
      output aso_out0_data,
      output aso_out0_valid,
      input  aso_out0_ready,
      output aso_out0_startofpacket,
      output aso_out0_endofpacket
   );

   modport master (
      output asi_in0_data,
      output asi_in0_valid,
      input  asi_in0_ready,
      input  aso_out0_data,
      input  aso_out0_valid,
      output aso_out0_ready,
      input  aso_out0_startofpacket,
      input  aso_out0_endofpacket
   );
endinterface

// File: rtl/bytes_to_packets.sv
// bytes_to_packets: packs BYTES_PER_SYMBOL bytes (first byte in the MS lane) into
// one output symbol and frames symbols into packets of cfg_symbols symbols
// (0 treated as 1) with SOP/EOP. One-deep output register, ready latency 0.
// Optional macro B2P_PKTCNT_EN adds a 16-bit wrapping stat_packets counter of
// EOP handshakes.
module bytes_to_packets #(
   parameter int BITS_PER_BYTE    = 8,
   parameter int BYTES_PER_SYMBOL = 8,
   parameter int LEN_W            = 13
) (
   input  logic             clock_clk,
   input  logic             reset_reset,
   input  logic [LEN_W-1:0] cfg_symbols,
   bytes_to_packets_if.slave st
`ifdef B2P_PKTCNT_EN
   ,
   output logic [15:0]      stat_packets
`endif
);

   localparam int SYM_W = BITS_PER_BYTE * BYTES_PER_SYMBOL;
   localparam int CNT_W = (BYTES_PER_SYMBOL > 1) ? $clog2(BYTES_PER_SYMBOL) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_SYMBOL - 1);

   typedef enum logic {
      IDLE,
      ACTIVE
   } pkt_state_t;

   pkt_state_t       state_q, state_d;
   logic [CNT_W-1:0] byte_cnt_q;
   logic [SYM_W-1:0] acc_q;
   logic [SYM_W-1:0] sym_next;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] sym_cnt_q, sym_cnt_d;
   logic [LEN_W-1:0] cfg_len;
   logic [LEN_W-1:0] eff_len;
   logic             sym_sop, sym_eop;

   logic [SYM_W-1:0] out_data_q;
   logic             out_valid_q;
   logic             out_sop_q;
   logic             out_eop_q;

   logic             in_ready;
   logic             accept;
   logic             last_byte;
   logic             out_stall;
   logic             out_xfer;

   // Zero-length request is framed as a single-symbol packet.
   assign cfg_len   = (cfg_symbols == '0) ? LEN_W'(1) : cfg_symbols;

   // Only the symbol-completing byte needs a free output register; earlier bytes
   // land in the accumulator and can always be taken.
   assign out_stall = out_valid_q & ~st.aso_out0_ready;
   assign in_ready  = ~((byte_cnt_q == LAST_IDX) & out_stall);
   assign accept    = st.asi_in0_valid & in_ready;
   assign last_byte = accept & (byte_cnt_q == LAST_IDX);
   assign out_xfer  = out_valid_q & st.aso_out0_ready;

   // Lane g takes the incoming byte when it is the g-th byte of the symbol,
   // otherwise keeps what the accumulator already holds.
   for (genvar g = 0; g < BYTES_PER_SYMBOL; g++) begin : g_lane
      assign sym_next[(BYTES_PER_SYMBOL-g)*BITS_PER_BYTE-1 -: BITS_PER_BYTE] =
         (byte_cnt_q == CNT_W'(g)) ? st.asi_in0_data
                                   : acc_q[(BYTES_PER_SYMBOL-g)*BITS_PER_BYTE-1 -: BITS_PER_BYTE];
   end

   // Packet state register with latched length and per-packet symbol counter.
   always_ff @(posedge clock_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q   <= IDLE;
         len_q     <= '0;
         sym_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         sym_cnt_q <= sym_cnt_d;
      end
   end

   // Packet framing: open on first accepted byte, close on the symbol whose
   // 1-based index equals the length. In IDLE the live cfg value is used so a
   // packet that opens and completes a symbol on the same edge frames correctly.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      sym_cnt_d = sym_cnt_q;
      eff_len   = (state_q == IDLE) ? cfg_len : len_q;
      sym_sop   = (sym_cnt_q == '0);
      sym_eop   = (sym_cnt_q == (eff_len - LEN_W'(1)));

      case (state_q)
         IDLE: begin
            if (accept) begin
               len_d   = cfg_len;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            state_d = ACTIVE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (last_byte) begin
         if (sym_eop) begin
            state_d   = IDLE;
            sym_cnt_d = '0;
         end else begin
            sym_cnt_d = sym_cnt_q + LEN_W'(1);
         end
      end
   end

   // Byte counter and partial-symbol accumulator.
   always_ff @(posedge clock_clk or posedge reset_reset) begin
      if (reset_reset) begin
         byte_cnt_q <= '0;
         acc_q      <= '0;
      end else if (accept) begin
         byte_cnt_q <= (byte_cnt_q == LAST_IDX) ? '0 : byte_cnt_q + CNT_W'(1);
         acc_q      <= sym_next;
      end
   end

   // Output register: load on last byte (also covers the same-edge handshake,
   // giving full throughput), clear valid/SOP/EOP on a plain handshake, hold otherwise.
   always_ff @(posedge clock_clk or posedge reset_reset) begin
      if (reset_reset) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
      end else if (last_byte) begin
         out_data_q  <= sym_next;
         out_valid_q <= 1'b1;
         out_sop_q   <= sym_sop;
         out_eop_q   <= sym_eop;
      end else if (out_xfer) begin
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
      end
   end

   assign st.asi_in0_ready          = in_ready;
   assign st.aso_out0_data          = out_data_q;
   assign st.aso_out0_valid         = out_valid_q;
   assign st.aso_out0_startofpacket = out_sop_q;
   assign st.aso_out0_endofpacket   = out_eop_q;

`ifdef B2P_PKTCNT_EN
   logic [15:0] pkt_cnt_q;

   // Count completed packets as they leave (EOP handshakes), wrapping at 16 bits.
   always_ff @(posedge clock_clk or posedge reset_reset) begin
      if (reset_reset) begin
         pkt_cnt_q <= '0;
      end else if (out_xfer && out_eop_q) begin
         pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
   end

   assign stat_packets = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_bytes_to_packets.sv
// tb_bytes_to_packets: directed and randomized stimulus for bytes_to_packets,
// checked every cycle against a queue-based packing/framing model, plus
// literal expectations for the reference streams.
module tb_bytes_to_packets;

   localparam int BPB   = 8;
   localparam int BPS   = 8;
   localparam int LEN_W = 13;
   localparam int SW    = BPB * BPS;

   logic             clock_clk = 1'b0;
   logic             reset_reset;
   logic [LEN_W-1:0] cfg_symbols;
`ifdef B2P_PKTCNT_EN
   logic [15:0]      stat_packets;
`endif

   bytes_to_packets_if #(.BITS_PER_BYTE(BPB), .BYTES_PER_SYMBOL(BPS)) bus();

   bytes_to_packets #(
      .BITS_PER_BYTE(BPB),
      .BYTES_PER_SYMBOL(BPS),
      .LEN_W(LEN_W)
   ) dut (
      .clock_clk(clock_clk),
      .reset_reset(reset_reset),
      .cfg_symbols(cfg_symbols),
      .st(bus)
`ifdef B2P_PKTCNT_EN
      ,
      .stat_packets(stat_packets)
`endif
   );

   always #5 clock_clk = ~clock_clk;

   int checks = 0;
   int errors = 0;

   // model state
   logic [BPB-1:0] parts[$];
   logic [SW-1:0]  exp_data[$];
   bit             exp_sop[$];
   bit             exp_eop[$];
   bit             pkt_open;
   int             pkt_len;
   int             sym_idx;
   logic [15:0]    pkt_count;

   // captured output handshakes
   logic [SW-1:0]  got_data[$];
   bit             got_sop[$];
   bit             got_eop[$];
   bit             saw_stall;
   bit             rnd_done;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_got();
      got_data.delete();
      got_sop.delete();
      got_eop.delete();
   endtask

   // Reference model and per-cycle compare, evaluated between clock edges.
   always @(negedge clock_clk) begin
      if (reset_reset) begin
         parts.delete();
         exp_data.delete();
         exp_sop.delete();
         exp_eop.delete();
         pkt_open  = 1'b0;
         pkt_count = '0;
         check("rst_valid", bus.aso_out0_valid, 0);
         check("rst_data", bus.aso_out0_data, 0);
         check("rst_sop", bus.aso_out0_startofpacket, 0);
         check("rst_eop", bus.aso_out0_endofpacket, 0);
         check("rst_in_ready", bus.asi_in0_ready, 1);
      end else begin
         check("out_valid", bus.aso_out0_valid, exp_data.size() > 0);
         if (bus.aso_out0_valid && exp_data.size() > 0) begin
            check("out_data", bus.aso_out0_data, exp_data[0]);
            check("out_sop", bus.aso_out0_startofpacket, exp_sop[0]);
            check("out_eop", bus.aso_out0_endofpacket, exp_eop[0]);
         end
         check("in_ready", bus.asi_in0_ready,
               !(parts.size() == BPS-1 && exp_data.size() > 0 && !bus.aso_out0_ready));
         if (!bus.asi_in0_ready) saw_stall = 1'b1;
`ifdef B2P_PKTCNT_EN
         check("stat_packets", stat_packets, pkt_count);
`endif
         if (bus.aso_out0_valid && bus.aso_out0_ready && exp_data.size() > 0) begin
            got_data.push_back(bus.aso_out0_data);
            got_sop.push_back(bus.aso_out0_startofpacket);
            got_eop.push_back(bus.aso_out0_endofpacket);
            if (exp_eop[0]) pkt_count = pkt_count + 16'd1;
            void'(exp_data.pop_front());
            void'(exp_sop.pop_front());
            void'(exp_eop.pop_front());
         end
         if (bus.asi_in0_valid && bus.asi_in0_ready) begin
            if (!pkt_open) begin
               pkt_open = 1'b1;
               pkt_len  = (cfg_symbols == 0) ? 1 : int'(cfg_symbols);
               sym_idx  = 0;
            end
            parts.push_back(bus.asi_in0_data);
            if (parts.size() == BPS) begin
               logic [SW-1:0] sym;
               sym = '0;
               foreach (parts[k]) sym = (sym << BPB) | SW'(parts[k]);
               exp_data.push_back(sym);
               exp_sop.push_back(sym_idx == 0);
               exp_eop.push_back(sym_idx + 1 == pkt_len);
               sym_idx++;
               if (sym_idx == pkt_len) pkt_open = 1'b0;
               parts.delete();
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock_clk);
      #1;
   endtask

   // Present one byte and hold it until the block takes it.
   task automatic send_byte(input logic [BPB-1:0] b);
      int n;
      n = 0;
      bus.asi_in0_data  = b;
      bus.asi_in0_valid = 1'b1;
      forever begin
         @(negedge clock_clk);
         if (bus.asi_in0_ready) break;
         n++;
         if (n > 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled expected=accepted byte=%0h", b);
            break;
         end
      end
      @(posedge clock_clk);
      #1;
      bus.asi_in0_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.aso_out0_ready = 1'b1;
      while ((bus.aso_out0_valid || exp_data.size() > 0) && n < 200) begin
         step(1);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d expected<200 cycles", n);
      end
      step(1);
   endtask

   logic [5:0] eops, sops;

   initial begin
      reset_reset       = 1'b1;
      cfg_symbols       = LEN_W'(4);
      bus.asi_in0_valid = 1'b0;
      bus.asi_in0_data  = '0;
      bus.aso_out0_ready = 1'b1;
      pkt_open = 1'b0;
      pkt_count = '0;
      #2;
      check("init_valid", bus.aso_out0_valid, 0);
      check("init_data", bus.aso_out0_data, 0);
      check("init_in_ready", bus.asi_in0_ready, 1);
      step(3);
      reset_reset = 1'b0;
      step(1);

      // reference stream 0x00..0x1F, 4-symbol packets
      clear_got();
      for (int i = 0; i < 32; i++) send_byte(BPB'(i));
      drain();
      check("ref_count", got_data.size(), 4);
      check("ref_sym0", got_data[0], 64'h0001020304050607);
      check("ref_sop0", got_sop[0], 1);
      check("ref_eop0", got_eop[0], 0);
      check("ref_sym3", got_data[3], 64'h18191A1B1C1D1E1F);
      check("ref_eop3", got_eop[3], 1);

      // single-symbol packets, length 1 and length 0
      for (int c = 1; c >= 0; c--) begin
         cfg_symbols = LEN_W'(c);
         clear_got();
         for (int i = 0; i < 16; i++) send_byte(BPB'($urandom));
         drain();
         check("len1_count", got_data.size(), 2);
         check("len1_flags", {got_sop[0], got_eop[0], got_sop[1], got_eop[1]}, 4'b1111);
      end

      // backpressure: output held off for 20 cycles during streaming
      cfg_symbols = LEN_W'(4);
      clear_got();
      saw_stall = 1'b0;
      fork
         for (int i = 0; i < 40; i++) send_byte(BPB'(8'h40 + i));
         begin
            step(3);
            bus.aso_out0_ready = 1'b0;
            step(20);
            bus.aso_out0_ready = 1'b1;
         end
      join
      drain();
      check("bp_stall_seen", saw_stall, 1);
      check("bp_count", got_data.size(), 5);
      check("bp_sym1", got_data[1], 64'h48494A4B4C4D4E4F);
      check("bp_sym4", got_data[4], 64'h6061626364656667);

      // reset in the middle of a packet with a symbol pending at the output
      bus.aso_out0_ready = 1'b0;
      for (int i = 0; i < 13; i++) send_byte(BPB'(8'h60 + i));
      check("pre_rst_valid", bus.aso_out0_valid, 1);
      #2;
      reset_reset = 1'b1;
      #1;
      check("mid_rst_valid", bus.aso_out0_valid, 0);
      check("mid_rst_data", bus.aso_out0_data, 0);
      check("mid_rst_sop", bus.aso_out0_startofpacket, 0);
      check("mid_rst_in_ready", bus.asi_in0_ready, 1);
      step(2);
      reset_reset = 1'b0;
      bus.aso_out0_ready = 1'b1;
      clear_got();
      for (int i = 0; i < 8; i++) send_byte(BPB'(8'hA0 + i));
      drain();
      check("post_rst_count", got_data.size(), 1);
      check("post_rst_sym", got_data[0], 64'hA0A1A2A3A4A5A6A7);
      check("post_rst_sop", got_sop[0], 1);

      // finish the 4-symbol packet opened above, then change length mid-packet
      for (int i = 0; i < 24; i++) send_byte(BPB'($urandom));
      drain();
      clear_got();
      cfg_symbols = LEN_W'(4);
      for (int i = 0; i < 8; i++) send_byte(BPB'(i));
      cfg_symbols = LEN_W'(2);
      for (int i = 0; i < 40; i++) send_byte(BPB'(8'h80 + i));
      drain();
      check("cfgchg_count", got_data.size(), 6);
      for (int i = 0; i < 6; i++) begin
         eops[5-i] = got_eop[i];
         sops[5-i] = got_sop[i];
      end
      check("cfgchg_eops", eops, 6'b000101);
      check("cfgchg_sops", sops, 6'b100010);

      // randomized traffic: gaps, back-pressure and length changes
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               if ($urandom_range(0, 7) == 0) cfg_symbols = LEN_W'($urandom_range(0, 3));
               if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
               send_byte(BPB'($urandom));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               bus.aso_out0_ready = ($urandom_range(0, 3) != 0);
               step(1);
            end
         end
      join
      drain();

`ifdef B2P_PKTCNT_EN
      // packet counter: three 1-symbol packets, each EOP stalled one cycle
      reset_reset = 1'b1;
      step(1);
      reset_reset = 1'b0;
      cfg_symbols = LEN_W'(1);
      bus.aso_out0_ready = 1'b0;
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 8; i++) send_byte(BPB'($urandom));
         step(1);
         check("pktcnt_stalled", stat_packets, 16'(p));
         bus.aso_out0_ready = 1'b1;
         step(1);
         check("pktcnt_after", stat_packets, 16'(p + 1));
         bus.aso_out0_ready = 1'b0;
      end
      drain();
      check("pktcnt_final", stat_packets, 16'd3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bytes_to_packets.md
BYTES_TO_PACKETS -- requirements
Module: bytes_to_packets

Interface
- REQ-001: Parameter BITS_PER_BYTE, default 8, byte width in bits (>=1).
- REQ-002: Parameter BYTES_PER_SYMBOL, default 8, bytes packed per output symbol (>=1).
- REQ-003: Parameter LEN_W, default 13, width of the packet-length input.
- REQ-004: clock_clk  in  1  sole clock; all logic on rising edge.
- REQ-005: reset_reset  in  1  asynchronous, active-high reset.
- REQ-006: cfg_symbols  in  LEN_W  symbols per packet; sampled per packet.
- REQ-007: asi_in0_data  in  BITS_PER_BYTE  input byte.
- REQ-008: asi_in0_valid  in  1  input byte valid.
- REQ-009: asi_in0_ready  out  1  block can accept a byte this cycle (ready latency 0).
- REQ-010: aso_out0_data  out  BYTES_PER_SYMBOL*BITS_PER_BYTE  packed symbol.
- REQ-011: aso_out0_valid  out  1  symbol valid.
- REQ-012: aso_out0_ready  in  1  downstream accepts symbol (ready latency 0).
- REQ-013: aso_out0_startofpacket  out  1  first symbol of packet, qualified by valid.
- REQ-014: aso_out0_endofpacket  out  1  last symbol of packet, qualified by valid.

Function
- REQ-015: A byte is accepted only on a cycle where asi_in0_valid and asi_in0_ready are both high.
- REQ-016: The first accepted byte of a symbol occupies the most-significant lane; byte k (0-based) occupies bits [(BYTES_PER_SYMBOL-k)*BITS_PER_BYTE-1 -: BITS_PER_BYTE].
- REQ-017: The byte counter counts 0..BYTES_PER_SYMBOL-1 and wraps to 0 when the last byte of a symbol is accepted.
- REQ-018: The completed symbol is loaded into the output register on the edge that accepts its last byte; aso_out0_valid rises the following cycle (latency 1 cycle from last byte).
- REQ-019: The output register holds data, valid, SOP and EOP stable while aso_out0_valid=1 and aso_out0_ready=0.
- REQ-020: asi_in0_ready is low only when the byte counter is BYTES_PER_SYMBOL-1, aso_out0_valid=1 and aso_out0_ready=0; otherwise it is high.
- REQ-021: Simultaneous last-byte acceptance and output handshake loads the new symbol with no bubble (full throughput: one symbol per BYTES_PER_SYMBOL cycles).
- REQ-022: A transfer with aso_out0_valid=1 and aso_out0_ready=1 and no new symbol clears aso_out0_valid.
- REQ-023: Packet FSM states: IDLE (no packet open) and ACTIVE (packet open).
- REQ-024: IDLE->ACTIVE on acceptance of a byte; cfg_symbols is latched on that edge, with value 0 treated as 1.
- REQ-025: ACTIVE->IDLE on the edge loading the symbol whose index equals the latched length; that symbol carries EOP=1.
- REQ-026: The first symbol of each packet carries SOP=1; when the latched length is 1, that symbol carries SOP=1 and EOP=1.
- REQ-027: The symbol counter saturates nowhere and resets to 0 at EOP; changes to cfg_symbols mid-packet have no effect until the next packet.

Reset
- REQ-028: Asserting reset_reset immediately clears aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket, both counters, the latched length and the FSM (IDLE), and zeroes aso_out0_data.
- REQ-029: Reset mid-packet discards the partial symbol and the open packet; the first byte after deassertion starts a new packet with SOP.
- REQ-030: asi_in0_ready is 1 during and after reset.

Configuration
- REQ-031: Macro B2P_PKTCNT_EN compiled in: add output stat_packets (16 bits), cleared by reset, incremented on each EOP output handshake, wrapping 0xFFFF->0.
- REQ-032: Macro B2P_PKTCNT_EN absent: stat_packets port and counter do not exist; all other behaviour is identical.

Verification
- REQ-033: Defaults, cfg_symbols=4, 32 bytes 0x00..0x1F streamed continuously, ready=1 -> 4-symbol packets: first symbol 0x0001020304050607 with SOP, fourth 0x18191A1B1C1D1E1F with EOP.
- REQ-034: cfg_symbols=1 -> every symbol has SOP=1 and EOP=1; cfg_symbols=0 gives the same result.
- REQ-035: aso_out0_ready held low 20 cycles during streaming -> asi_in0_ready drops at byte 7 of the next symbol, the output holds stable, and no byte is lost or duplicated after release.
- REQ-036: Reset asserted after 13 bytes of a packet -> outputs are 0 immediately; the next 8 bytes form a symbol with SOP=1.
- REQ-037: cfg_symbols changed 4->2 mid-packet -> the current packet ends after 4 symbols and the next ends after 2.
- REQ-038: B2P_PKTCNT_EN defined, 3 packets sent with EOP stalled one cycle -> stat_packets=3, incrementing only on each EOP handshake.
